ps2_rx_frame: RTL and testbench

Receive-only PS/2 front end. Synchronizes and deglitches the raw `PS2_CLK`/`PS2_DAT` lines, deserializes 11-bit device-to-host frames, checks parity and stop bit, and emits one scan-code byte per good frame. Sits directly upstream of `keyboard_tracker`, which consumes the byte stream and maintains the per-key hold/pulse outputs.

---
 rtl/ps2_rx_frame_pkg.sv | 16 +
 rtl/ps2_edge_filter.sv | 60 ++++++
 rtl/ps2_rx_frame.sv | 151 +++++++++++++++
 tb/tb_ps2_rx_frame.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_rx_frame_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive front end.
package ps2_pkg;

    // Frame deserializer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam int         PS2_DATA_BITS    = 8;

endpackage

// File: rtl/ps2_edge_filter.sv
// ps2_edge_filter: two-flop synchronizers on both PS/2 lines, a FILTER_LEN
// deglitcher on the clock line and a registered falling-edge strobe.
module ps2_edge_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_fall,
    output logic dat_sync
);
    import ps2_pkg::*;

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          clk_s1, clk_s2;
    logic          dat_s1, dat_s2;
    logic          clk_filt;
    logic [CW-1:0] run_cnt;

    // Synchronize both lines; idle-high lines reset to 1 so no edge fires after reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Flip the filtered clock only after FILTER_LEN samples disagree with it in a row
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_filt <= 1'b1;
            run_cnt  <= '0;
            clk_fall <= 1'b0;
        end else begin
            clk_fall <= 1'b0;
            if (clk_s2 == clk_filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                run_cnt  <= '0;
                // old level high means this flip is a 1->0 transition
                clk_fall <= clk_filt;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    assign dat_sync = dat_s2;

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver. Emits one byte per good
// frame, with parity / framing / timeout error pulses.
// Optional feature macro: PS2_RX_BREAK_DECODE_EN adds E0/F0 prefix decoding
// and the key_code / key_ext / key_release / key_valid outputs.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       parity_err,
`ifdef PS2_RX_BREAK_DECODE_EN
    output logic       frame_err,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_valid
`else
    output logic       frame_err
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic                     clk_fall;
    logic                     dat_sync;
    ps2_state_t               state;
    logic [2:0]               bit_cnt;
    logic [PS2_DATA_BITS-1:0] shreg;
    logic                     par_bit;
    logic [TW-1:0]            tcnt;
    logic                     timeout;

    ps2_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (PS2_CLK),
        .ps2_dat  (PS2_DAT),
        .clk_fall (clk_fall),
        .dat_sync (dat_sync)
    );

    assign timeout = (state != ST_IDLE) && !clk_fall && (tcnt == TW'(TIMEOUT_CYCLES));

    // Inter-edge watchdog: cleared by every edge, frozen at zero while idle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (clk_fall || state == ST_IDLE || timeout) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Frame FSM; all result pulses are registered and mutually exclusive
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            scan_code  <= 8'h00;
            scan_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (clk_fall) begin
                case (state)
                    ST_IDLE: begin
                        // a high "start" bit is a line glitch, silently ignored
                        if (!dat_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {dat_sync, shreg[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(PS2_DATA_BITS - 1))
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= dat_sync;
                        state   <= ST_STOP;
                    end
                    default: begin
                        // framing error takes precedence over parity
                        if (!dat_sync) begin
                            frame_err <= 1'b1;
                        end else if (!(^{shreg, par_bit})) begin
                            parity_err <= 1'b1;
                        end else begin
                            scan_code  <= shreg;
                            scan_valid <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                endcase
            end else if (timeout) begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
            end
        end
    end

`ifdef PS2_RX_BREAK_DECODE_EN
    logic ext_flag, rel_flag;

    // Fold E0/F0 prefixes into sticky flags attached to the next plain byte
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext_flag    <= 1'b0;
            rel_flag    <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_valid   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (parity_err || frame_err) begin
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
            end else if (scan_valid) begin
                if (scan_code == PS2_EXT_PREFIX) begin
                    ext_flag <= 1'b1;
                end else if (scan_code == PS2_BREAK_PREFIX) begin
                    rel_flag <= 1'b1;
                end else begin
                    key_code    <= scan_code;
                    key_ext     <= ext_flag;
                    key_release <= rel_flag;
                    key_valid   <= 1'b1;
                    ext_flag    <= 1'b0;
                    rel_flag    <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: directed self-checking bench for ps2_rx_frame.
module tb_ps2_rx_frame;

    localparam int FLEN = 4;
    localparam int TMO  = 300;
    localparam int H    = 20;   // PS/2 half period in system clocks

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, parity_err, frame_err;
`ifdef PS2_RX_BREAK_DECODE_EN
    logic [7:0] key_code;
    logic       key_ext, key_release, key_valid;
    int         n_key = 0;
    logic [7:0] last_key = 8'h00;
    logic       last_ext = 1'b0, last_rel = 1'b0;
`endif

    ps2_rx_frame #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .parity_err (parity_err),
`ifdef PS2_RX_BREAK_DECODE_EN
        .frame_err  (frame_err),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_release(key_release),
        .key_valid  (key_valid)
`else
        .frame_err  (frame_err)
`endif
    );

    always #5 clock = ~clock;

    // Pulse counters sampled on the falling edge
    int n_valid = 0, n_perr = 0, n_ferr = 0, n_multi = 0;
    always @(negedge clock) begin
        if (scan_valid) n_valid++;
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
        if (int'(scan_valid) + int'(parity_err) + int'(frame_err) > 1) n_multi++;
`ifdef PS2_RX_BREAK_DECODE_EN
        if (key_valid) begin
            n_key++;
            last_key = key_code;
            last_ext = key_ext;
            last_rel = key_release;
        end
`endif
    end

    int checks = 0, fails = 0;
    int b_valid, b_perr, b_ferr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_valid = n_valid;
        b_perr  = n_perr;
        b_ferr  = n_ferr;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
    endtask

    // One PS/2 bit; optional 2-cycle low glitch in the high phase
    task automatic send_bit(input logic b, input logic glitch);
        PS2_DAT = b;
        if (glitch) begin
            cyc(H / 2);
            PS2_CLK = 1'b0;
            cyc(2);
            PS2_CLK = 1'b1;
            cyc(H - H / 2 - 2);
        end else begin
            cyc(H);
        end
        PS2_CLK = 1'b0;
        cyc(H);
        PS2_CLK = 1'b1;
    endtask

    // Send the first nbits of a frame; glitch_at picks the bit that gets a glitch (-1 none)
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int nbits, input int glitch_at);
        logic [10:0] fr;
        fr = {stp, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(fr[i], i == glitch_at);
        PS2_DAT = 1'b1;
        cyc(H);
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    initial begin
        cyc(3);
        #1;
        check("rst_scan_code", scan_code, 8'h00);
        check("rst_scan_valid", scan_valid, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        reset = 1'b1;
        cyc(10);

        // good 8'h29
        snap();
        send_frame(8'h29, 1'b0, 1'b1, 11, -1);
        check("f29_valid", n_valid - b_valid, 1);
        check("f29_code", scan_code, 8'h29);
        check("f29_perr", n_perr - b_perr, 0);
        check("f29_ferr", n_ferr - b_ferr, 0);

        // bad parity
        snap();
        send_frame(8'h29, 1'b1, 1'b1, 11, -1);
        check("par_perr", n_perr - b_perr, 1);
        check("par_valid", n_valid - b_valid, 0);
        check("par_code_held", scan_code, 8'h29);

        // truncated frame then timeout
        snap();
        send_frame(8'h29, 1'b0, 1'b1, 5, -1);
        cyc(TMO + 10);
        check("tmo_ferr", n_ferr - b_ferr, 1);
        check("tmo_valid", n_valid - b_valid, 0);
        snap();
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        check("after_tmo_valid", n_valid - b_valid, 1);
        check("after_tmo_code", scan_code, 8'h1C);
        check("after_tmo_ferr", n_ferr - b_ferr, 0);

        // glitch in high phase of data bit 3
        snap();
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 11, 4);
        check("glitch_valid", n_valid - b_valid, 1);
        check("glitch_code", scan_code, 8'h5A);
        check("glitch_ferr", n_ferr - b_ferr, 0);

        // reset after 5th data bit
        snap();
        send_frame(8'h1C, 1'b0, 1'b1, 6, -1);
        reset = 1'b0;
        cyc(3);
        #1;
        check("midrst_code", scan_code, 8'h00);
        reset = 1'b1;
        cyc(5);
        send_frame(8'h29, 1'b0, 1'b1, 11, -1);
        check("midrst_valid", n_valid - b_valid, 1);
        check("midrst_code29", scan_code, 8'h29);
        check("midrst_errs", (n_ferr - b_ferr) + (n_perr - b_perr), 0);

        // back-to-back frames with no extra idle
        snap();
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 11, -1);
        check("b2b_valid", n_valid - b_valid, 2);
        check("b2b_code", scan_code, 8'h5A);

        // bad stop bit; parity also wrong but must not be reported
        snap();
        send_frame(8'h29, 1'b1, 1'b0, 11, -1);
        check("stop_ferr", n_ferr - b_ferr, 1);
        check("stop_perr", n_perr - b_perr, 0);
        check("stop_valid", n_valid - b_valid, 0);
        check("stop_code_held", scan_code, 8'h5A);

`ifdef PS2_RX_BREAK_DECODE_EN
        begin
            int k0;
            k0 = n_key;
            send_frame(8'hF0, odd_par(8'hF0), 1'b1, 11, -1);
            send_frame(8'h29, odd_par(8'h29), 1'b1, 11, -1);
            check("brk_kvalid", n_key - k0, 1);
            check("brk_code", last_key, 8'h29);
            check("brk_rel", last_rel, 1'b1);
            check("brk_ext", last_ext, 1'b0);
            k0 = n_key;
            send_frame(8'hE0, odd_par(8'hE0), 1'b1, 11, -1);
            send_frame(8'hF0, odd_par(8'hF0), 1'b1, 11, -1);
            send_frame(8'h75, odd_par(8'h75), 1'b1, 11, -1);
            check("ext_kvalid", n_key - k0, 1);
            check("ext_code", last_key, 8'h75);
            check("ext_ext", last_ext, 1'b1);
            check("ext_rel", last_rel, 1'b1);
        end
`endif

        check("one_pulse_at_a_time", n_multi, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
